uart_reg_bridge: RTL and testbench

- Command parser between the byte UART (buart) and the peripheral register bus.
- Consumes received bytes, decodes write and read transactions, and drives register-bus strobes.
- Queues response bytes (ack, echoes, read data) back to the UART transmitter.
- This is the protocol engine the serial_test top instantiates behind its UART.

---
 rtl/uart_reg_bridge.sv | 204 ++++++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bridge.sv
`default_nettype none
// uart_reg_bridge: parses UART byte commands into register-bus reads/writes
// and queues the reply bytes (ACK, or cmd/addr echo plus read data) back out.
module uart_reg_bridge #(
  parameter int unsigned CLK_FREQUENCY = 100_000_000,
  parameter int unsigned BYTE_TIMEOUT  = CLK_FREQUENCY / 100,
  parameter int unsigned BUS_TIMEOUT   = 255,
  parameter logic [7:0]  ACK_BYTE      = 8'h06,
  parameter logic [31:0] ERR_DATA      = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_rd_o,
  input  logic        tx_busy_i,
  output logic        tx_wr_o,
  output logic [7:0]  tx_data_o,
  output logic [7:0]  reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic        reg_wr_o,
  output logic        reg_rd_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_rvalid_i,
  output logic        err_o
);

  localparam int unsigned BT_W = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam int unsigned WT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_ADDR = 3'd1,
    S_GET_DATA = 3'd2,
    S_BUS_WR   = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_SEND     = 3'd5
  } state_t;

  state_t            state_q;
  logic              rx_rd_q;
  logic              rx_blind_q;
  logic              byte_vld_q;
  logic [7:0]        byte_q;
  logic [7:0]        cmd_q;
  logic [7:0]        addr_q;
  logic [23:0]       wsh_q;
  logic [1:0]        dcnt_q;
  logic [BT_W-1:0]   btmr_q;
  logic [WT_W-1:0]   wtmr_q;
  logic [47:0]       txq_q;
  logic [2:0]        txcnt_q;
  logic [1:0]        hold_q;
  logic              tx_wr_q;
  logic [7:0]        tx_data_q;
  logic [7:0]        reg_addr_q;
  logic [31:0]       reg_wdata_q;
  logic              reg_wr_q;
  logic              reg_rd_q;
  logic              err_q;
  logic              rx_rd_d;

  // Pop a byte only outside the two-cycle blind window after a pop; bytes
  // offered during BUS_WR wait one cycle and then fall under SEND discard.
  assign rx_rd_d = rx_valid_i && !rx_rd_q && !rx_blind_q && (state_q != S_BUS_WR);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      rx_rd_q     <= 1'b0;
      rx_blind_q  <= 1'b0;
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      cmd_q       <= '0;
      addr_q      <= '0;
      wsh_q       <= '0;
      dcnt_q      <= '0;
      btmr_q      <= '0;
      wtmr_q      <= '0;
      txq_q       <= '0;
      txcnt_q     <= '0;
      hold_q      <= '0;
      tx_wr_q     <= 1'b0;
      tx_data_q   <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_rd_q    <= rx_rd_d;
      rx_blind_q <= rx_rd_q;
      byte_vld_q <= rx_rd_d;
      if (rx_rd_d) byte_q <= rx_data_i;
      reg_wr_q <= 1'b0;
      reg_rd_q <= 1'b0;
      tx_wr_q  <= 1'b0;
      err_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          btmr_q <= '0;
          if (byte_vld_q) begin
            cmd_q   <= byte_q;
            state_q <= S_GET_ADDR;
          end
        end

        S_GET_ADDR: begin
          if (byte_vld_q) begin
            addr_q <= byte_q;
            btmr_q <= '0;
            dcnt_q <= '0;
            if (cmd_q[7]) begin
              reg_addr_q <= byte_q;
              reg_rd_q   <= 1'b1;
              wtmr_q     <= '0;
              state_q    <= S_RD_WAIT;
            end else begin
              state_q <= S_GET_DATA;
            end
          end else if (btmr_q == BT_W'(BYTE_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            btmr_q <= btmr_q + BT_W'(1);
          end
        end

        S_GET_DATA: begin
          if (byte_vld_q) begin
            btmr_q <= '0;
            dcnt_q <= dcnt_q + 2'd1;
            wsh_q  <= {byte_q, wsh_q[23:8]};
            // Address and data are committed only with the strobe, so an
            // abandoned write leaves the bus outputs untouched.
            if (dcnt_q == 2'd3) begin
              reg_addr_q  <= addr_q;
              reg_wdata_q <= {byte_q, wsh_q};
              reg_wr_q    <= 1'b1;
              state_q     <= S_BUS_WR;
            end
          end else if (btmr_q == BT_W'(BYTE_TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            btmr_q <= btmr_q + BT_W'(1);
          end
        end

        S_BUS_WR: begin
          txq_q   <= {40'h0, ACK_BYTE};
          txcnt_q <= 3'd1;
          hold_q  <= '0;
          state_q <= S_SEND;
        end

        S_RD_WAIT: begin
          if (reg_rvalid_i) begin
            txq_q   <= {reg_rdata_i, addr_q, cmd_q};
            txcnt_q <= 3'd6;
            hold_q  <= '0;
            state_q <= S_SEND;
          end else if (wtmr_q == WT_W'(BUS_TIMEOUT - 1)) begin
            txq_q   <= {ERR_DATA, addr_q, cmd_q};
            txcnt_q <= 3'd6;
            hold_q  <= '0;
            err_q   <= 1'b1;
            state_q <= S_SEND;
          end else begin
            wtmr_q <= wtmr_q + WT_W'(1);
          end
        end

        S_SEND: begin
          // The hold-off masks the lag before the transmitter raises busy.
          if (hold_q != 2'd0) begin
            hold_q <= hold_q - 2'd1;
          end else if (!tx_busy_i) begin
            tx_wr_q   <= 1'b1;
            tx_data_q <= txq_q[7:0];
            txq_q     <= {8'h00, txq_q[47:8]};
            txcnt_q   <= txcnt_q - 3'd1;
            hold_q    <= 2'd2;
            if (txcnt_q == 3'd1) state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rx_rd_o     = rx_rd_q;
  assign tx_wr_o     = tx_wr_q;
  assign tx_data_o   = tx_data_q;
  assign reg_addr_o  = reg_addr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign reg_wr_o    = reg_wr_q;
  assign reg_rd_o    = reg_rd_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_reg_bridge.sv
`default_nettype none
// Bench for uart_reg_bridge: directed commands; expected bus writes and
// transmit bytes are queued up front and checked by a separate monitor.
module tb_uart_reg_bridge;

  localparam int BYTE_TO = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic [31:0] reg_rdata = 32'h0;
  logic        reg_rvalid = 1'b0;
  logic        rx_rd_o, tx_wr_o, reg_wr_o, reg_rd_o, err_o;
  logic [7:0]  tx_data_o, reg_addr_o;
  logic [31:0] reg_wdata_o;

  uart_reg_bridge #(
    .CLK_FREQUENCY(100_000_000),
    .BYTE_TIMEOUT (BYTE_TO),
    .BUS_TIMEOUT  (255),
    .ACK_BYTE     (8'h06),
    .ERR_DATA     (32'hDEAD_BEEF)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .rx_valid_i  (rx_valid),
    .rx_data_i   (rx_data),
    .rx_rd_o     (rx_rd_o),
    .tx_busy_i   (tx_busy),
    .tx_wr_o     (tx_wr_o),
    .tx_data_o   (tx_data_o),
    .reg_addr_o  (reg_addr_o),
    .reg_wdata_o (reg_wdata_o),
    .reg_wr_o    (reg_wr_o),
    .reg_rd_o    (reg_rd_o),
    .reg_rdata_i (reg_rdata),
    .reg_rvalid_i(reg_rvalid),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  exp_tx[$];
  logic [39:0] exp_wr[$];
  logic [31:0] mem [256];
  int cyc = 0, rx_rd_cnt = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0, tx_cnt = 0;
  int wr_cyc = 0, rd_cyc = 0, err_cyc = 0;
  logic prev_rx_rd = 1'b0;
  logic busy_force = 1'b0;
  logic bus_en = 1'b1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset) begin
        if (rx_rd_o) begin
          rx_rd_cnt++;
          chk("rx_rd_single_cycle", 64'(prev_rx_rd), 0);
        end
        if (reg_wr_o) begin
          wr_cnt++;
          wr_cyc = cyc;
          chk("reg_wr_latency", 64'(prev_rx_rd), 1);
          if (exp_wr.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL reg_wr_unexpected: got addr %0h data %0h expected none", reg_addr_o, reg_wdata_o);
          end else begin
            chk("reg_wr_addr_data", {reg_addr_o, reg_wdata_o}, exp_wr.pop_front());
          end
          mem[reg_addr_o] = reg_wdata_o;
        end
        if (reg_rd_o) begin
          rd_cnt++;
          rd_cyc = cyc;
          chk("reg_rd_latency", 64'(prev_rx_rd), 1);
        end
        if (err_o) begin
          err_cnt++;
          err_cyc = cyc;
        end
        if (tx_wr_o) begin
          tx_cnt++;
          if (exp_tx.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL tx_unexpected: got %0h expected none", tx_data_o);
          end else begin
            chk("tx_byte", tx_data_o, exp_tx.pop_front());
          end
        end
      end
      prev_rx_rd = rx_rd_o;
    end
  end

  // UART transmitter model: busy rises one cycle after tx_wr, then stays 6 cycles
  initial begin
    int  busy_cnt = 0;
    logic lag = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_wr_o && !reset) chk("tx_wr_spacing", {62'h0, lag, tx_busy}, 0);
      if (busy_cnt != 0) busy_cnt--;
      if (lag) begin busy_cnt = 6; lag = 1'b0; end
      if (tx_wr_o) lag = 1'b1;
      tx_busy = busy_force || (busy_cnt != 0);
    end
  end

  // Register bus model: read data appears a few cycles after reg_rd
  initial begin
    logic [7:0] a;
    forever begin
      @(negedge clk);
      if (reg_rd_o && bus_en && !reset) begin
        a = reg_addr_o;
        repeat (2) @(negedge clk);
        reg_rdata  = mem[a];
        reg_rvalid = 1'b1;
        @(negedge clk);
        reg_rvalid = 1'b0;
        reg_rdata  = 32'h0;
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    logic got = 1'b0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_rd_o) begin got = 1'b1; break; end
    end
    chk("rx_byte_popped", 64'(got), 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] a, input logic [31:0] d);
    send_byte(8'h01);
    send_byte(a);
    send_byte(d[7:0]);
    send_byte(d[15:8]);
    send_byte(d[23:16]);
    send_byte(d[31:24]);
  endtask

  task automatic wait_tx_done(input string nm);
    int i = 0;
    while (exp_tx.size() != 0 && i < 3000) begin
      @(negedge clk);
      i++;
    end
    chk({nm, "_tx_drained"}, 64'(exp_tx.size()), 0);
    repeat (5) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, "_strobes"}, {59'h0, rx_rd_o, tx_wr_o, reg_wr_o, reg_rd_o, err_o}, 0);
    chk({nm, "_tx_data"}, 64'(tx_data_o), 0);
    chk({nm, "_reg_addr"}, 64'(reg_addr_o), 0);
    chk({nm, "_reg_wdata"}, 64'(reg_wdata_o), 0);
  endtask

  initial begin
    int s_wr, s_rd, s_rx, s_err, s_tx, i;
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    mem[8'h44] = 32'hCAFE_F00D;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    reset = 1'b0;

    // Write 12345678 to 10, one dummy byte discarded while the ACK is pending
    s_wr = wr_cnt; s_rx = rx_rd_cnt;
    exp_wr.push_back({8'h10, 32'h1234_5678});
    exp_tx.push_back(8'h06);
    busy_force = 1'b1;
    send_write(8'h10, 32'h1234_5678);
    send_byte(8'hFF);
    busy_force = 1'b0;
    wait_tx_done("write");
    chk("write_reg_wr_count", 64'(wr_cnt - s_wr), 1);
    chk("write_rx_rd_count", 64'(rx_rd_cnt - s_rx), 7);
    chk("write_addr_hold", 64'(reg_addr_o), 64'h10);
    chk("write_data_hold", 64'(reg_wdata_o), 64'h1234_5678);

    // Read back 10 with six dummy clocking bytes
    s_rd = rd_cnt; s_rx = rx_rd_cnt;
    exp_tx.push_back(8'h81); exp_tx.push_back(8'h10);
    exp_tx.push_back(8'h78); exp_tx.push_back(8'h56);
    exp_tx.push_back(8'h34); exp_tx.push_back(8'h12);
    busy_force = 1'b1;
    send_byte(8'h81);
    send_byte(8'h10);
    repeat (6) send_byte(8'hFF);
    busy_force = 1'b0;
    wait_tx_done("read");
    chk("read_reg_rd_count", 64'(rd_cnt - s_rd), 1);
    chk("read_rx_rd_count", 64'(rx_rd_cnt - s_rx), 8);

    // Byte timeout mid-write, then a full write succeeds
    s_wr = wr_cnt; s_err = err_cnt;
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'hAA);
    repeat (BYTE_TO + 60) @(negedge clk);
    chk("byte_timeout_err_count", 64'(err_cnt - s_err), 1);
    chk("byte_timeout_no_reg_wr", 64'(wr_cnt - s_wr), 0);
    chk("byte_timeout_wdata_kept", 64'(reg_wdata_o), 64'h1234_5678);
    exp_wr.push_back({8'h20, 32'h0000_0001});
    exp_tx.push_back(8'h06);
    send_write(8'h20, 32'h0000_0001);
    wait_tx_done("after_timeout_write");
    chk("after_timeout_reg_wr_count", 64'(wr_cnt - s_wr), 1);

    // Bus timeout: no reg_rvalid, ERR_DATA returned
    bus_en = 1'b0;
    s_err = err_cnt;
    exp_tx.push_back(8'h81); exp_tx.push_back(8'h05);
    exp_tx.push_back(8'hEF); exp_tx.push_back(8'hBE);
    exp_tx.push_back(8'hAD); exp_tx.push_back(8'hDE);
    send_byte(8'h81);
    send_byte(8'h05);
    wait_tx_done("bus_timeout");
    chk("bus_timeout_err_count", 64'(err_cnt - s_err), 1);
    chk("bus_timeout_latency", 64'(err_cyc - rd_cyc), 255);
    bus_en = 1'b1;

    // Reset while sending the read reply, after two bytes went out
    s_tx = tx_cnt;
    exp_tx.push_back(8'h82); exp_tx.push_back(8'h44);
    send_byte(8'h82);
    send_byte(8'h44);
    i = 0;
    while ((tx_cnt - s_tx) < 2 && i < 500) begin
      @(negedge clk);
      i++;
    end
    chk("reset_mid_send_reached", 64'(tx_cnt - s_tx), 2);
    reset = 1'b1;
    @(negedge clk);
    chk_outputs_zero("reset_mid_send");
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("reset_mid_send_no_more_tx", 64'(tx_cnt - s_tx), 2);
    s_wr = wr_cnt;
    exp_wr.push_back({8'h55, 32'hDDCC_BBAA});
    exp_tx.push_back(8'h06);
    send_write(8'h55, 32'hDDCC_BBAA);
    wait_tx_done("after_reset_write");
    chk("after_reset_reg_wr_count", 64'(wr_cnt - s_wr), 1);

    // Write then read the same address
    exp_wr.push_back({8'h33, 32'h0A0B_0C0D});
    exp_tx.push_back(8'h06);
    send_write(8'h33, 32'h0A0B_0C0D);
    wait_tx_done("b2b_write");
    exp_tx.push_back(8'h81); exp_tx.push_back(8'h33);
    exp_tx.push_back(8'h0D); exp_tx.push_back(8'h0C);
    exp_tx.push_back(8'h0B); exp_tx.push_back(8'h0A);
    send_byte(8'h81);
    send_byte(8'h33);
    wait_tx_done("b2b_read");
    chk("b2b_wr_before_rd", 64'(wr_cyc < rd_cyc), 1);
    chk("b2b_reg_addr", 64'(reg_addr_o), 64'h33);

    chk("no_pending_reg_wr", 64'(exp_wr.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
